// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Merges NUM_CH cache/uncache request ports (0 = icache, 1 = dcache, 2 = uncache)
//   onto a single downstream read/write port. Reads and writes are arbitrated
//   independently, each with its own round-robin pointer. A read is held off while
//   a granted write to the same cache line has not yet seen mem_wr_ok.
// Ports
//   clk, resetn                       clock, async active-low reset
//   ch_rd_req/type/addr, ch_rd_rdy    per-channel read request / accept
//   ch_ret_valid/last/data            read return (valid routed to owner, data/last broadcast)
//   ch_wr_req/type/addr/wstrb/data    per-channel write request
//   ch_wr_rdy                         per-channel write accept
//   mem_rd_*, mem_ret_*               downstream read request and return
//   mem_wr_*, mem_wr_ok               downstream write request and completion
module mem_req_arbiter #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                                clk,
    input  logic                                resetn,
    // channel read side
    input  logic [NUM_CH-1:0]                   ch_rd_req,
    input  logic [3*NUM_CH-1:0]                 ch_rd_type,
    input  logic [ADDR_W*NUM_CH-1:0]            ch_rd_addr,
    output logic [NUM_CH-1:0]                   ch_rd_rdy,
    output logic [NUM_CH-1:0]                   ch_ret_valid,
    output logic                                ch_ret_last,
    output logic [DATA_W-1:0]                   ch_ret_data,
    // channel write side
    input  logic [NUM_CH-1:0]                   ch_wr_req,
    input  logic [3*NUM_CH-1:0]                 ch_wr_type,
    input  logic [ADDR_W*NUM_CH-1:0]            ch_wr_addr,
    input  logic [4*NUM_CH-1:0]                 ch_wr_wstrb,
    input  logic [LINE_WORDS*DATA_W*NUM_CH-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]                   ch_wr_rdy,
    // downstream read
    output logic                                mem_rd_req,
    output logic [2:0]                          mem_rd_type,
    output logic [ADDR_W-1:0]                   mem_rd_addr,
    input  logic                                mem_rd_rdy,
    input  logic                                mem_ret_valid,
    input  logic                                mem_ret_last,
    input  logic [DATA_W-1:0]                   mem_ret_data,
    // downstream write
    output logic                                mem_wr_req,
    output logic [2:0]                          mem_wr_type,
    output logic [ADDR_W-1:0]                   mem_wr_addr,
    output logic [3:0]                          mem_wr_wstrb,
    output logic [LINE_WORDS*DATA_W-1:0]        mem_wr_data,
    input  logic                                mem_wr_rdy,
    input  logic                                mem_wr_ok
);

    localparam int unsigned WR_W  = LINE_WORDS * DATA_W;
    localparam int unsigned OFF_W = $clog2(WR_W / 8);
    localparam int unsigned TAG_W = ADDR_W - OFF_W;
    localparam int unsigned CH_W  = $clog2(NUM_CH);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wstate_t;

    rstate_t             rstate, rstate_nxt;
    wstate_t             wstate, wstate_nxt;
    logic [CH_W-1:0]     rd_grant, rd_grant_nxt, rd_rr, rd_rr_nxt;
    logic [CH_W-1:0]     wr_grant, wr_grant_nxt, wr_rr, wr_rr_nxt;
    logic [2:0]          rd_type_nxt, wr_type_nxt;
    logic [ADDR_W-1:0]   rd_addr_nxt, wr_addr_nxt;
    logic [3:0]          wr_wstrb_nxt;
    logic [WR_W-1:0]     wr_data_nxt;
    logic [NUM_CH-1:0]   rd_elig;
    logic [CH_W-1:0]     rd_pick, wr_pick;
    logic                wr_busy;

    // First set bit of elig at or above ptr, wrapping modulo NUM_CH.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                                 input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] sel;
        logic            found;
        int unsigned     idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(ptr) + k) % NUM_CH;
            if (!found && elig[CH_W'(idx)]) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
        return sel;
    endfunction

    // Write latch only describes an outstanding write once wstate has left W_IDLE,
    // so a write granted in the same cycle never blocks a read.
    assign wr_busy = (wstate != W_IDLE);

    // Read eligibility: requesting and not on the line of an unacknowledged write.
    always_comb begin
        rd_elig = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            rd_elig[c] = ch_rd_req[c] &&
                !(wr_busy && (ch_rd_addr[c*ADDR_W+OFF_W +: TAG_W] == mem_wr_addr[ADDR_W-1:OFF_W]));
        end
    end

    assign rd_pick = rr_pick(rd_elig, rd_rr);
    assign wr_pick = rr_pick(ch_wr_req, wr_rr);

    // Read FSM next state, latch updates and channel-side read outputs.
    always_comb begin
        rstate_nxt   = rstate;
        rd_grant_nxt = rd_grant;
        rd_rr_nxt    = rd_rr;
        rd_type_nxt  = mem_rd_type;
        rd_addr_nxt  = mem_rd_addr;
        ch_rd_rdy    = '0;
        ch_ret_valid = '0;
        ch_ret_last  = 1'b0;
        ch_ret_data  = '0;
        case (rstate)
            R_IDLE: begin
                if (|rd_elig) begin
                    rstate_nxt   = R_REQ;
                    rd_grant_nxt = rd_pick;
                    rd_type_nxt  = ch_rd_type[32'(rd_pick)*3 +: 3];
                    rd_addr_nxt  = ch_rd_addr[32'(rd_pick)*ADDR_W +: ADDR_W];
                end
            end
            R_REQ: begin
                ch_rd_rdy[rd_grant] = mem_rd_rdy;
                if (mem_rd_rdy) begin
                    rstate_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                ch_ret_valid[rd_grant] = mem_ret_valid;
                ch_ret_last            = mem_ret_last;
                ch_ret_data            = mem_ret_data;
                if (mem_ret_valid && mem_ret_last) begin
                    rstate_nxt = R_IDLE;
                    rd_rr_nxt  = CH_W'((32'(rd_grant) + 1) % NUM_CH);
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // Write FSM next state, latch updates and channel-side write accept.
    always_comb begin
        wstate_nxt   = wstate;
        wr_grant_nxt = wr_grant;
        wr_rr_nxt    = wr_rr;
        wr_type_nxt  = mem_wr_type;
        wr_addr_nxt  = mem_wr_addr;
        wr_wstrb_nxt = mem_wr_wstrb;
        wr_data_nxt  = mem_wr_data;
        ch_wr_rdy    = '0;
        case (wstate)
            W_IDLE: begin
                if (|ch_wr_req) begin
                    wstate_nxt   = W_REQ;
                    wr_grant_nxt = wr_pick;
                    wr_type_nxt  = ch_wr_type[32'(wr_pick)*3 +: 3];
                    wr_addr_nxt  = ch_wr_addr[32'(wr_pick)*ADDR_W +: ADDR_W];
                    wr_wstrb_nxt = ch_wr_wstrb[32'(wr_pick)*4 +: 4];
                    wr_data_nxt  = ch_wr_data[32'(wr_pick)*WR_W +: WR_W];
                end
            end
            W_REQ: begin
                ch_wr_rdy[wr_grant] = mem_wr_rdy;
                if (mem_wr_rdy) begin
                    wstate_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                // Line hazard stays up here until the B response arrives.
                if (mem_wr_ok) begin
                    wstate_nxt = W_IDLE;
                    wr_rr_nxt  = CH_W'((32'(wr_grant) + 1) % NUM_CH);
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // State, pointers and downstream request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate       <= R_IDLE;
            rd_grant     <= '0;
            rd_rr        <= '0;
            mem_rd_req   <= 1'b0;
            mem_rd_type  <= '0;
            mem_rd_addr  <= '0;
            wstate       <= W_IDLE;
            wr_grant     <= '0;
            wr_rr        <= '0;
            mem_wr_req   <= 1'b0;
            mem_wr_type  <= '0;
            mem_wr_addr  <= '0;
            mem_wr_wstrb <= '0;
            mem_wr_data  <= '0;
        end else begin
            rstate       <= rstate_nxt;
            rd_grant     <= rd_grant_nxt;
            rd_rr        <= rd_rr_nxt;
            mem_rd_req   <= (rstate_nxt == R_REQ);
            mem_rd_type  <= rd_type_nxt;
            mem_rd_addr  <= rd_addr_nxt;
            wstate       <= wstate_nxt;
            wr_grant     <= wr_grant_nxt;
            wr_rr        <= wr_rr_nxt;
            mem_wr_req   <= (wstate_nxt == W_REQ);
            mem_wr_type  <= wr_type_nxt;
            mem_wr_addr  <= wr_addr_nxt;
            mem_wr_wstrb <= wr_wstrb_nxt;
            mem_wr_data  <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: inputs change on the falling edge,
// outputs are sampled on the falling edge (+1 for combinational paths).
module tb_mem_req_arbiter;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LW     = 8;
    localparam int unsigned WR_W   = LW * DATA_W;

    logic                      clk = 1'b0;
    logic                      resetn = 1'b1;
    logic [NUM_CH-1:0]         ch_rd_req;
    logic [3*NUM_CH-1:0]       ch_rd_type;
    logic [ADDR_W*NUM_CH-1:0]  ch_rd_addr;
    logic [NUM_CH-1:0]         ch_rd_rdy;
    logic [NUM_CH-1:0]         ch_ret_valid;
    logic                      ch_ret_last;
    logic [DATA_W-1:0]         ch_ret_data;
    logic [NUM_CH-1:0]         ch_wr_req;
    logic [3*NUM_CH-1:0]       ch_wr_type;
    logic [ADDR_W*NUM_CH-1:0]  ch_wr_addr;
    logic [4*NUM_CH-1:0]       ch_wr_wstrb;
    logic [WR_W*NUM_CH-1:0]    ch_wr_data;
    logic [NUM_CH-1:0]         ch_wr_rdy;
    logic                      mem_rd_req;
    logic [2:0]                mem_rd_type;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic                      mem_rd_rdy;
    logic                      mem_ret_valid;
    logic                      mem_ret_last;
    logic [DATA_W-1:0]         mem_ret_data;
    logic                      mem_wr_req;
    logic [2:0]                mem_wr_type;
    logic [ADDR_W-1:0]         mem_wr_addr;
    logic [3:0]                mem_wr_wstrb;
    logic [WR_W-1:0]           mem_wr_data;
    logic                      mem_wr_rdy;
    logic                      mem_wr_ok;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    mem_req_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn),
        .ch_rd_req(ch_rd_req), .ch_rd_type(ch_rd_type), .ch_rd_addr(ch_rd_addr),
        .ch_rd_rdy(ch_rd_rdy), .ch_ret_valid(ch_ret_valid), .ch_ret_last(ch_ret_last),
        .ch_ret_data(ch_ret_data),
        .ch_wr_req(ch_wr_req), .ch_wr_type(ch_wr_type), .ch_wr_addr(ch_wr_addr),
        .ch_wr_wstrb(ch_wr_wstrb), .ch_wr_data(ch_wr_data), .ch_wr_rdy(ch_wr_rdy),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
        .mem_ret_data(mem_ret_data),
        .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
        .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
        .mem_wr_ok(mem_wr_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WR_W-1:0] got, input logic [WR_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge with the read FSM in R_REQ: accept, return beats, finish.
    task automatic read_txn(input int ch, input logic [31:0] addr, input logic [2:0] typ,
                            input int beats, input bit drop);
        check("rd_req_up", 32'(mem_rd_req), 32'd1);
        check("rd_addr", 32'(mem_rd_addr), 32'(addr));
        check("rd_type", 32'(mem_rd_type), 32'(typ));
        check("rd_rdy_wait", 32'(ch_rd_rdy), 32'd0);
        mem_rd_rdy = 1'b1;
        #1;
        check("rd_rdy_grant", 32'(ch_rd_rdy), 32'(1 << ch));
        cyc();
        mem_rd_rdy = 1'b0;
        if (drop) ch_rd_req[ch] = 1'b0;
        for (int b = 0; b < beats; b++) begin
            mem_ret_valid = 1'b1;
            mem_ret_last  = (b == beats - 1);
            mem_ret_data  = 32'hB000_0000 + 32'(ch * 16 + b);
            #1;
            check("ret_valid", 32'(ch_ret_valid), 32'(1 << ch));
            check("ret_data", 32'(ch_ret_data), 32'hB000_0000 + 32'(ch * 16 + b));
            check("ret_last", 32'(ch_ret_last), 32'(b == beats - 1));
            cyc();
        end
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
        #1;
        check("rd_back_idle", 32'(mem_rd_req), 32'd0);
    endtask

    initial begin
        ch_rd_req = '0; ch_rd_type = '0; ch_rd_addr = '0;
        ch_wr_req = '0; ch_wr_type = '0; ch_wr_addr = '0; ch_wr_wstrb = '0; ch_wr_data = '0;
        mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
        mem_wr_rdy = 1'b0; mem_wr_ok = 1'b0;

        // reset values
        #1 resetn = 1'b0;
        #1;
        check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        check("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
        check("rst_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_mem_wr_data", mem_wr_data, '0);
        check("rst_ch_rd_rdy", 32'(ch_rd_rdy), 32'd0);
        check("rst_ch_wr_rdy", 32'(ch_wr_rdy), 32'd0);
        check("rst_ch_ret_valid", 32'(ch_ret_valid), 32'd0);
        repeat (2) cyc();
        resetn = 1'b1;
        cyc();

        // spurious return beat while idle
        mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hDEAD_BEEF;
        #1;
        check("spur_ret_valid", 32'(ch_ret_valid), 32'd0);
        cyc();
        check("spur_ret_valid2", 32'(ch_ret_valid), 32'd0);
        check("spur_rd_req", 32'(mem_rd_req), 32'd0);
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

        // single line read on dcache channel
        ch_rd_type[5:3]   = 3'b100;
        ch_rd_addr[63:32] = 32'h1FC0_0100;
        ch_rd_req         = 3'b010;
        #1;
        check("t1_not_yet", 32'(mem_rd_req), 32'd0);
        cyc();
        read_txn(1, 32'h1FC0_0100, 3'b100, 8, 1'b1);

        // reset during R_WAIT after three beats
        ch_rd_req = 3'b010;
        cyc();
        check("t6_rd_req", 32'(mem_rd_req), 32'd1);
        mem_rd_rdy = 1'b1;
        cyc();
        mem_rd_rdy = 1'b0; ch_rd_req = 3'b000;
        for (int b = 0; b < 3; b++) begin
            mem_ret_valid = 1'b1; mem_ret_data = 32'h0000_0C00 + 32'(b);
            cyc();
        end
        mem_ret_valid = 1'b1; mem_ret_data = 32'h0000_0C03;
        #1;
        check("t6_beat4_valid", 32'(ch_ret_valid), 32'b010);
        #1 resetn = 1'b0;
        #1;
        check("t6_rst_ret_valid", 32'(ch_ret_valid), 32'd0);
        check("t6_rst_ret_data", 32'(ch_ret_data), 32'd0);
        check("t6_rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        check("t6_rst_rd_rdy", 32'(ch_rd_rdy), 32'd0);
        mem_ret_valid = 1'b0;
        cyc();
        resetn = 1'b1;

        // round robin from a fresh pointer, all channels held: 0,1,2,0
        ch_rd_type = {3'b010, 3'b010, 3'b010};
        ch_rd_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        ch_rd_req  = 3'b111;
        cyc();
        read_txn(0, 32'h0000_0100, 3'b010, 1, 1'b0);
        cyc();
        read_txn(1, 32'h0000_0200, 3'b010, 1, 1'b0);
        cyc();
        read_txn(2, 32'h0000_0300, 3'b010, 1, 1'b0);
        cyc();
        read_txn(0, 32'h0000_0100, 3'b010, 2, 1'b0);
        ch_rd_req = 3'b000;

        // write to line 0x1020 holds a read of 0x1030 (same 32-byte line)
        ch_wr_type[5:3]    = 3'b100;
        ch_wr_addr[63:32]  = 32'h0000_1020;
        ch_wr_wstrb[7:4]   = 4'hF;
        ch_wr_data[511:256] = {8{32'hC0DE_1020}};
        ch_wr_req          = 3'b010;
        cyc();
        check("t3_wr_req", 32'(mem_wr_req), 32'd1);
        check("t3_wr_addr", 32'(mem_wr_addr), 32'h0000_1020);
        check("t3_wr_type", 32'(mem_wr_type), 32'd4);
        check("t3_wr_wstrb", 32'(mem_wr_wstrb), 32'hF);
        check("t3_wr_data", mem_wr_data, {8{32'hC0DE_1020}});
        check("t3_wr_rdy_wait", 32'(ch_wr_rdy), 32'd0);
        mem_wr_rdy = 1'b1;
        #1;
        check("t3_wr_rdy", 32'(ch_wr_rdy), 32'b010);
        cyc();
        mem_wr_rdy = 1'b0; ch_wr_req = 3'b000;
        #1;
        check("t3_wr_req_low", 32'(mem_wr_req), 32'd0);
        ch_rd_addr[63:32] = 32'h0000_1030;
        ch_rd_req         = 3'b010;
        repeat (2) begin
            cyc();
            check("t3_raw_block", 32'(mem_rd_req), 32'd0);
        end
        // adjacent line 0x1000 is not blocked; ch1 is skipped by the arbiter
        ch_rd_addr[95:64] = 32'h0000_1000;
        ch_rd_req[2]      = 1'b1;
        cyc();
        read_txn(2, 32'h0000_1000, 3'b010, 1, 1'b1);
        cyc();
        check("t3_raw_still", 32'(mem_rd_req), 32'd0);
        mem_wr_ok = 1'b1;
        cyc();
        mem_wr_ok = 1'b0;
        #1;
        check("t3_ok_cycle", 32'(mem_rd_req), 32'd0);
        cyc();
        read_txn(1, 32'h0000_1030, 3'b010, 1, 1'b1);

        // read and write of the same line granted together
        ch_rd_addr[31:0]    = 32'h0000_3004;
        ch_wr_type[5:3]     = 3'b010;
        ch_wr_addr[63:32]   = 32'h0000_3000;
        ch_wr_wstrb[7:4]    = 4'h3;
        ch_wr_data[511:256] = {8{32'h3000_00AA}};
        ch_rd_req = 3'b001;
        ch_wr_req = 3'b010;
        cyc();
        check("t4_wr_req", 32'(mem_wr_req), 32'd1);
        check("t4_wr_addr", 32'(mem_wr_addr), 32'h0000_3000);
        read_txn(0, 32'h0000_3004, 3'b010, 1, 1'b1);
        mem_wr_rdy = 1'b1;
        #1;
        check("t4_wr_rdy", 32'(ch_wr_rdy), 32'b010);
        cyc();
        mem_wr_rdy = 1'b0; ch_wr_req = 3'b000;

        // completion and a new write request in the same cycle
        ch_wr_type[8:6]    = 3'b000;
        ch_wr_addr[95:64]  = 32'h0000_4000;
        ch_wr_wstrb[11:8]  = 4'h1;
        ch_wr_data[767:512] = {8{32'h4444_0001}};
        mem_wr_ok = 1'b1;
        ch_wr_req = 3'b100;
        cyc();
        mem_wr_ok = 1'b0;
        #1;
        check("t_ok_no_grant", 32'(mem_wr_req), 32'd0);
        cyc();
        check("t_ok_next_grant", 32'(mem_wr_req), 32'd1);
        check("t_ok_addr", 32'(mem_wr_addr), 32'h0000_4000);
        check("t_ok_wstrb", 32'(mem_wr_wstrb), 32'h1);
        mem_wr_rdy = 1'b1;
        #1;
        check("t_ok_wr_rdy", 32'(ch_wr_rdy), 32'b100);
        cyc();
        mem_wr_rdy = 1'b0; ch_wr_req = 3'b000;
        mem_wr_ok = 1'b1;
        cyc();
        mem_wr_ok = 1'b0;
        #1;
        check("t_final_idle", 32'(mem_wr_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
